hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised Tuse/Tnew hazard unit for the in-order MIPS pipeline; sits beside the D stage.
- Tracks pending register writes for every post-D stage in an internal shift register of write descriptors.
- Decides D-stage stall and bubble insertion.
- Produces forward-select and forwarded data for both D source operands (rs, rt).
- Generalises the fixed E/M/W forwarding to STAGES stages, configurable data/address width and Tnew range, plus an external freeze.

Parameters:
- STAGES, 3, number of tracked stages after D (index 0 = E, STAGES-1 = W).
- DW, 32, register data width.
- AW, 5, register address width.
- TW, 2, width of Tuse/Tnew fields.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  freeze all tracking (e.g. memory wait).
- d_valid  in  1  D holds a real instruction.
- d_rs_addr, d_rt_addr  in  AW each  D source registers.
- d_rs_tuse, d_rt_tuse  in  TW each  cycles from D until each operand is consumed.
- d_wr_addr  in  AW  D destination register (0 = none).
- d_wr_tnew  in  TW  Tnew the instruction will carry on entering E.
- d_rs_raw, d_rt_raw  in  DW each  register-file read data.
- stage_wdata  in  STAGES*DW  result held in each stage's pipeline register; slice k belongs to stage k.
- stall  out  1  freeze F/D and inject a bubble into E.
- rs_sel, rt_sel  out  $clog2(STAGES+1) each  0 = register file; k+1 = forwarded from stage k.
- rs_pend, rt_pend  out  1 each  matching producer has 0 < tnew <= tuse; value is forwarded by a later-stage mux.
- rs_data, rt_data  out  DW each  resolved operands.

Behaviour:
- Entry per stage: {valid, addr[AW], tnew[TW]}. Any entry with addr == 0 is forced invalid.
- Reset (async, reset = 0):
  - All entries invalid, tnew = 0.
  - stall, sel, pend = 0; rs_data/rt_data = raw inputs (purely combinational from entries).
- Rising edge with hold = 0:
  - Entry k+1 <= entry k, with tnew decremented and saturating at 0.
  - Entry STAGES-1 is discarded.
  - Entry 0 <= {d_valid & ~stall & (d_wr_addr != 0), d_wr_addr, d_wr_tnew}; a stall inserts a bubble (valid = 0).
- hold = 1: no entry changes. hold wins over stall; stall is still reported combinationally.
- Per-source match (addr != 0, d_valid = 1): the youngest (lowest k) valid entry with equal addr wins. Older matches are ignored.
- stall = OR over sources of (match && tnew_k > tuse). The stall output is combinational; zero latency.
- sel = k+1 and data = stage_wdata[k] when the winning match has tnew_k == 0.
- pend = 1, sel = 0, data = raw when 0 < tnew_k <= tuse.
- No match: sel = 0, data = raw.
- Register $0: never matched, never stalls, data = raw.
- rs_addr == rt_addr: both resolved identically and independently.
- Multiple stages holding the same addr: youngest wins (WAW-correct).
- Reset asserted mid-stall: all pending state is lost and stall drops immediately.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits): counts cycles with stall = 1 && hold = 0, saturating at 0xFFFFFFFF.
  - Adds output fwd_cnt (32 bits): counts cycles where rs_sel or rt_sel is nonzero.
  - Both counters clear on reset.
- Undefined: neither port nor its logic exists; behaviour otherwise identical.

Decomposition:
- Package haz_pkg:
  - entry struct;
  - TW/AW defaults;
  - SEL_RF = 0 constant;
  - function sel_of_stage(k).
- One sub-module, haz_match: priority match of one source against all entries, producing hit, stage index and tnew. Instantiated twice (rs, rt).

Test Plan:
- ALU producer: addu $8 in E with tnew = 1; D beq reads $8 with tuse = 0 -> stall = 1. Next cycle $8 is in M with tnew = 0 -> stall = 0, rs_sel = 2, rs_data = stage_wdata[1] = 0x0000_1234.
- Load-use: lw $9 with tnew = 2 in E; D addu rt = $9 with tuse = 1 -> exactly one stall cycle. Then rt_pend = 1, rt_sel = 0.
- $0 writer: d_wr_addr = 0, tnew = 2; next instruction reads $0 with tuse = 0 -> stall = 0, rs_sel = 0, rs_data = d_rs_raw = 0.
- WAW: $10 in M (tnew = 0, data 0xAAAA) and in W (data 0xBBBB); D reads $10 -> rs_sel = 2, rs_data = 0xAAAA.
- hold = 1 for 3 cycles during a load-use stall -> entries unchanged and stall stays 1; after release the stall resolves in 1 cycle. With HAZ_PERF_CNT_EN, stall_cnt increments by 1, not 4.
- reset pulled low while lw is in E and stall = 1 -> stall = 0 asynchronously; after release, reading $9 gives rs_sel = 0 and no stall.

Source files
------------

// File: rtl/haz_pkg.sv
// haz_pkg: shared types and helpers for the Tuse/Tnew hazard scoreboard.
package haz_pkg;
  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;
  // Entry fields are sized for the widest supported configuration; narrower builds zero-extend.
  localparam int AW_MAX = 16;
  localparam int TW_MAX = 8;
  localparam int SEL_RF = 0;
  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] addr;
    logic [TW_MAX-1:0] tnew;
  } entry_t;
  function automatic int sel_of_stage(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/haz_match.sv
// haz_match: youngest-first match of one source register against all pending write entries.
module haz_match
  import haz_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int AW     = AW_DEF,
  parameter int IW     = 2
) (
  input  entry_t            i_e [STAGES],
  input  logic              i_en,
  input  logic [AW-1:0]     i_addr,
  output logic              o_hit,
  output logic [IW-1:0]     o_idx,
  output logic [TW_MAX-1:0] o_tnew
);
  // Scan oldest to youngest so the lowest matching stage overwrites any older hit.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    o_tnew = '0;
    for (int k = STAGES - 1; k >= 0; k--)
      if (i_en && i_e[k].valid && i_e[k].addr == AW_MAX'(i_addr)) begin
        o_hit  = 1'b1;
        o_idx  = IW'(k);
        o_tnew = i_e[k].tnew;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage Tuse/Tnew stall and forwarding unit over STAGES tracked stages.
// Optional HAZ_PERF_CNT_EN adds stall_cnt / fwd_cnt performance counters.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int DW     = 32,
  parameter int AW     = AW_DEF,
  parameter int TW     = TW_DEF,
  localparam int SW    = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 d_valid,
  input  logic [AW-1:0]        d_rs_addr,
  input  logic [AW-1:0]        d_rt_addr,
  input  logic [TW-1:0]        d_rs_tuse,
  input  logic [TW-1:0]        d_rt_tuse,
  input  logic [AW-1:0]        d_wr_addr,
  input  logic [TW-1:0]        d_wr_tnew,
  input  logic [DW-1:0]        d_rs_raw,
  input  logic [DW-1:0]        d_rt_raw,
  input  logic [STAGES*DW-1:0] stage_wdata,
  output logic                 stall,
  output logic [SW-1:0]        rs_sel,
  output logic [SW-1:0]        rt_sel,
  output logic                 rs_pend,
  output logic                 rt_pend,
  output logic [DW-1:0]        rs_data,
  output logic [DW-1:0]        rt_data
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`endif
);
  entry_t            r_e [STAGES];
  entry_t            w_new;
  logic              w_rs_hit, w_rt_hit, w_rs_stall, w_rt_stall, w_rs_fwd, w_rt_fwd;
  logic [SW-1:0]     w_rs_idx, w_rt_idx;
  logic [TW_MAX-1:0] w_rs_tnew, w_rt_tnew;
  always_comb begin
    w_new = '0;
    if (d_valid && !stall && d_wr_addr != '0) begin
      w_new.valid = 1'b1;
      w_new.addr  = AW_MAX'(d_wr_addr);
      w_new.tnew  = TW_MAX'(d_wr_tnew);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      r_e <= '{default: '0};
    else if (!hold) begin
      r_e[0] <= w_new;
      for (int k = 1; k < STAGES; k++)
        r_e[k] <= '{valid: r_e[k-1].valid, addr: r_e[k-1].addr,
                    tnew: (r_e[k-1].tnew != '0) ? r_e[k-1].tnew - TW_MAX'(1) : '0};
    end
  haz_match #(.STAGES(STAGES), .AW(AW), .IW(SW)) u_rs_match (
    .i_e(r_e), .i_en(d_valid && d_rs_addr != '0), .i_addr(d_rs_addr),
    .o_hit(w_rs_hit), .o_idx(w_rs_idx), .o_tnew(w_rs_tnew)
  );
  haz_match #(.STAGES(STAGES), .AW(AW), .IW(SW)) u_rt_match (
    .i_e(r_e), .i_en(d_valid && d_rt_addr != '0), .i_addr(d_rt_addr),
    .o_hit(w_rt_hit), .o_idx(w_rt_idx), .o_tnew(w_rt_tnew)
  );
  assign w_rs_stall = w_rs_hit && w_rs_tnew > TW_MAX'(d_rs_tuse);
  assign w_rt_stall = w_rt_hit && w_rt_tnew > TW_MAX'(d_rt_tuse);
  assign w_rs_fwd   = w_rs_hit && w_rs_tnew == '0;
  assign w_rt_fwd   = w_rt_hit && w_rt_tnew == '0;
  assign stall      = w_rs_stall | w_rt_stall;
  assign rs_pend    = w_rs_hit && w_rs_tnew != '0 && !w_rs_stall;
  assign rt_pend    = w_rt_hit && w_rt_tnew != '0 && !w_rt_stall;
  assign rs_sel     = w_rs_fwd ? SW'(sel_of_stage(int'(w_rs_idx))) : SW'(SEL_RF);
  assign rt_sel     = w_rt_fwd ? SW'(sel_of_stage(int'(w_rt_idx))) : SW'(SEL_RF);
  assign rs_data    = w_rs_fwd ? stage_wdata[int'(w_rs_idx)*DW +: DW] : d_rs_raw;
  assign rt_data    = w_rt_fwd ? stage_wdata[int'(w_rt_idx)*DW +: DW] : d_rt_raw;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_fwd_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && !hold && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (rs_sel != '0 || rt_sel != '0) r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan scenarios plus randomized traffic against an issue-time model.
module tb_hazard_scoreboard;
  localparam int ST = 3, DW = 32, AW = 5, TW = 2, SW = 2;
  logic clk = 1'b0, reset, hold, d_valid;
  logic [AW-1:0] d_rs_addr, d_rt_addr, d_wr_addr;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_wr_tnew;
  logic [DW-1:0] d_rs_raw, d_rt_raw, rs_data, rt_data;
  logic [ST*DW-1:0] stage_wdata;
  logic stall, rs_pend, rt_pend;
  logic [SW-1:0] rs_sel, rt_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt, cnt0;
`endif
  always #5 clk = ~clk;
  hazard_scoreboard #(.STAGES(ST), .DW(DW), .AW(AW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .d_valid(d_valid),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_wr_addr(d_wr_addr), .d_wr_tnew(d_wr_tnew), .d_rs_raw(d_rs_raw), .d_rt_raw(d_rt_raw),
    .stage_wdata(stage_wdata), .stall(stall), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .rs_pend(rs_pend), .rt_pend(rt_pend), .rs_data(rs_data), .rt_data(rt_data)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );
  // Model: each accepted write remembers how many pipeline advances had happened when it issued.
  typedef struct {int addr; int tnew; int t;} wr_t;
  wr_t q[$];
  int adv = 0, n_tests = 0, n_fail = 0;
  bit exp_stall;
  function automatic void resolve(input int a, input int tu, input logic [DW-1:0] raw,
                                  output bit st, output int sel, output bit pend, output logic [DW-1:0] d);
    int best = -1, s, tn;
    st = 0; sel = 0; pend = 0; d = raw;
    if (!d_valid || a == 0) return;
    foreach (q[i]) if (q[i].addr == a && (best < 0 || q[i].t > q[best].t)) best = i;
    if (best < 0) return;
    s  = adv - q[best].t;
    tn = (q[best].tnew > s) ? q[best].tnew - s : 0;
    if (tn > tu) st = 1;
    else if (tn == 0) begin sel = s + 1; d = stage_wdata[s*DW +: DW]; end
    else pend = 1;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic peek();
    bit s0, s1, p0, p1;
    int l0, l1;
    logic [DW-1:0] x0, x1;
    #1;
    resolve(int'(d_rs_addr), int'(d_rs_tuse), d_rs_raw, s0, l0, p0, x0);
    resolve(int'(d_rt_addr), int'(d_rt_tuse), d_rt_raw, s1, l1, p1, x1);
    exp_stall = s0 | s1;
    check("stall", stall, exp_stall);
    check("rs_sel", rs_sel, l0);
    check("rt_sel", rt_sel, l1);
    check("rs_pend", rs_pend, p0);
    check("rt_pend", rt_pend, p1);
    check("rs_data", rs_data, x0);
    check("rt_data", rt_data, x1);
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) q.delete();
    else if (!hold) begin
      adv++;
      if (d_valid && !exp_stall && d_wr_addr != 0)
        q.push_back('{int'(d_wr_addr), int'(d_wr_tnew), adv});
      while (q.size() > 0 && adv - q[0].t >= ST) void'(q.pop_front());
    end
    @(negedge clk);
  endtask
  task automatic instr(input bit v, input int ra, input int ru, input int ta, input int tu,
                       input int wa, input int wt);
    d_valid = v; d_rs_addr = AW'(ra); d_rs_tuse = TW'(ru); d_rt_addr = AW'(ta);
    d_rt_tuse = TW'(tu); d_wr_addr = AW'(wa); d_wr_tnew = TW'(wt);
  endtask
  task automatic flush();
    instr(0, 0, 0, 0, 0, 0, 0);
    repeat (ST) begin peek(); tick(); end
  endtask
  initial begin
    reset = 0; hold = 0; d_rs_raw = 32'h5555_0001; d_rt_raw = 32'h6666_0002;
    stage_wdata = {32'hBBBB, 32'hAAAA, 32'h0};
    instr(1, 8, 0, 9, 0, 0, 0);
    @(negedge clk);
    peek(); check("rst_stall", stall, 0); check("rst_rs_data", rs_data, 32'h5555_0001);
    tick();
    reset = 1;
    // ALU producer then branch consumer
    instr(1, 0, 0, 0, 0, 8, 1); peek(); tick();
    instr(1, 8, 0, 0, 0, 0, 0); stage_wdata = {32'h0, 32'h1234, 32'h0};
    peek(); check("alu_stall", stall, 1); tick();
    peek(); check("alu_stall2", stall, 0); check("alu_sel", rs_sel, 2); check("alu_data", rs_data, 32'h1234); tick();
    flush();
    // load-use: one stall cycle, then pending
    instr(1, 0, 0, 0, 0, 9, 2); peek(); tick();
    instr(1, 0, 0, 9, 1, 0, 0); peek(); check("lu_stall", stall, 1); tick();
    peek(); check("lu_stall2", stall, 0); check("lu_pend", rt_pend, 1); check("lu_sel", rt_sel, 0); tick();
    flush();
    // $0 writer is never tracked
    instr(1, 0, 0, 0, 0, 0, 2); peek(); tick();
    d_rs_raw = 0; instr(1, 0, 0, 0, 0, 0, 0);
    peek(); check("z_stall", stall, 0); check("z_sel", rs_sel, 0); check("z_data", rs_data, 0); tick();
    flush();
    // WAW: youngest copy of $10 wins
    instr(1, 0, 0, 0, 0, 10, 0); peek(); tick(); peek(); tick();
    instr(0, 0, 0, 0, 0, 0, 0); peek(); tick();
    instr(1, 10, 0, 0, 0, 0, 0); stage_wdata = {32'hBBBB, 32'hAAAA, 32'h0};
    peek(); check("waw_sel", rs_sel, 2); check("waw_data", rs_data, 32'hAAAA); tick();
    flush();
    // hold during a load-use stall
    instr(1, 0, 0, 0, 0, 9, 2); peek(); tick();
    instr(1, 0, 0, 9, 1, 0, 0); hold = 1;
`ifdef HAZ_PERF_CNT_EN
    cnt0 = stall_cnt;
`endif
    repeat (3) begin peek(); check("hold_stall", stall, 1); tick(); end
    hold = 0; peek(); check("rel_stall", stall, 1); tick();
    peek(); check("rel_stall2", stall, 0); tick();
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt", stall_cnt - cnt0, 1);
`endif
    flush();
    // asynchronous reset during a stall
    instr(1, 0, 0, 0, 0, 9, 2); peek(); tick();
    instr(1, 9, 0, 0, 0, 0, 0); peek(); check("ar_stall", stall, 1);
    reset = 0; q.delete(); #1; check("ar_drop", stall, 0);
    tick(); reset = 1;
    peek(); check("ar_sel", rs_sel, 0); check("ar_nostall", stall, 0); tick();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      if (!reset) q.delete();
      hold = ($urandom_range(0, 7) == 0);
      instr($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      d_rs_raw = $urandom; d_rt_raw = $urandom; stage_wdata = {$urandom, $urandom, $urandom};
      peek(); tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
